// File: rtl/cc1200_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cc1200_pkg
// Brief   : Shared constants, state encoding and frame builder for the CC1200
//           SPI register-access engine.
// Revision: 1.0 - initial release
// ============================================================================
package cc1200_pkg;

    localparam logic [5:0] EXT_ADDR_PREFIX = 6'h2F;
    localparam logic [7:0] STROBE_MIN      = 8'h30;
    localparam logic [7:0] STROBE_MAX      = 8'h3D;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Outgoing bytes left-aligned in bits[23:0] (first byte in [23:16]).
    typedef struct packed {
        logic [23:0] bits;
        logic [1:0]  nbytes;
    } frame_t;

    function automatic frame_t build_frame(
        input logic       rw,
        input logic       ext,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        frame_t     f;
        logic [7:0] data;
        logic [7:0] addr6;
        data  = rw ? 8'h00 : wdata;
        addr6 = {2'b00, addr[5:0]};
        if (ext) begin
            f.bits   = {rw, 1'b0, EXT_ADDR_PREFIX, addr, data};
            f.nbytes = 2'd3;
        end else if (addr6 >= STROBE_MIN && addr6 <= STROBE_MAX) begin
            f.bits   = {rw, 1'b0, addr[5:0], 16'h0000};
            f.nbytes = 2'd1;
        end else begin
            f.bits   = {rw, 1'b0, addr[5:0], data, 8'h00};
            f.nbytes = 2'd2;
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc1200_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module  : cc1200_sclk_gen
// Brief   : Mode-0 SCLK divider with low-phase-start and sample-point strobes.
// Revision: 1.0 - initial release
// ============================================================================
module cc1200_sclk_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic low_start,
    output logic sample
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_phase_end;

    assign w_phase_end = (r_cnt == CW'(CLK_DIV - 1));

    // Disabled divider parks at the start of a low phase so the first bit
    // of a frame gets a full low half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_phase_end) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign sclk      = r_phase;
    assign low_start = en && !r_phase && (r_cnt == '0);
    assign sample    = en &&  r_phase && w_phase_end;

endmodule
`default_nettype wire

// File: rtl/cc1200_spi_master.sv
`default_nettype none
// ============================================================================
// Module  : cc1200_spi_master
// Brief   : CC1200 register/strobe access engine driving the SPI pins.
// Revision: 1.0 - initial release
// ============================================================================
module cc1200_spi_master
    import cc1200_pkg::*;
#(
    parameter int CLK_DIV     = 5,
    parameter int RDY_TIMEOUT = 1024,
    parameter int CS_HOLD     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic       cmd_ext,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] rsp_status,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       SCLK_0,
    output logic       MOSI_0,
    input  logic       MISO_0,
    output logic       CS_n_0
);

    localparam int TW = $clog2(RDY_TIMEOUT + 1);
    localparam int HW = $clog2(CS_HOLD + 1);

    state_t        r_state;
    state_t        w_next;
    frame_t        w_frame;
    logic [23:0]   r_tx;
    logic [23:0]   r_rx;
    logic [1:0]    r_nbytes;
    logic          r_rw;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic          r_shift_end;
    logic          r_timeout;
    logic [TW-1:0] r_to_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_mosi;
    logic          r_miso_meta;
    logic          r_miso_sync;
    logic          w_sclk_en;
    logic          w_low_start;
    logic          w_sample;
    logic          w_to_expire;
    logic          w_last_bit;
    logic [7:0]    w_status;

    assign w_frame     = build_frame(cmd_rw, cmd_ext, cmd_addr, cmd_wdata);
    assign w_to_expire = (r_to_cnt == TW'(RDY_TIMEOUT - 1));
    assign w_last_bit  = w_sample && (r_bit == 3'd7) &&
                         (r_byte == 2'(r_nbytes - 2'd1));

    cc1200_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (w_sclk_en),
        .sclk      (SCLK_0),
        .low_start (w_low_start),
        .sample    (w_sample)
    );

    // Idles high so a released bus never reads as CHIP_RDYn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miso_meta <= 1'b1;
            r_miso_sync <= 1'b1;
        end else begin
            r_miso_meta <= MISO_0;
            r_miso_sync <= r_miso_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (cmd_valid)                w_next = CS_SETUP;
            CS_SETUP: if (!r_miso_sync)             w_next = SHIFT;
                      else if (w_to_expire)         w_next = HOLD;
            SHIFT:    if (r_shift_end)              w_next = HOLD;
            HOLD:     if (r_hold_cnt == HW'(CS_HOLD - 1)) w_next = DONE;
            DONE:                                   w_next = IDLE;
            default:                                w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        rsp_valid = (r_state == DONE);
        CS_n_0    = !((r_state == CS_SETUP) || (r_state == SHIFT));
        w_sclk_en = (r_state == SHIFT) && !r_shift_end;
    end

    assign MOSI_0 = r_mosi;

    always_comb begin
        case (r_nbytes)
            2'd1:    w_status = r_rx[7:0];
            2'd2:    w_status = r_rx[15:8];
            default: w_status = r_rx[23:16];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx        <= '0;
            r_rx        <= '0;
            r_nbytes    <= 2'd0;
            r_rw        <= 1'b0;
            r_bit       <= 3'd0;
            r_byte      <= 2'd0;
            r_shift_end <= 1'b0;
            r_timeout   <= 1'b0;
            r_to_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_mosi      <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_status  <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            r_hold_cnt <= '0;
            case (r_state)
                IDLE: begin
                    r_mosi <= 1'b0;
                    if (cmd_valid) begin
                        r_tx        <= w_frame.bits;
                        r_nbytes    <= w_frame.nbytes;
                        r_rw        <= cmd_rw;
                        r_rx        <= '0;
                        r_bit       <= 3'd0;
                        r_byte      <= 2'd0;
                        r_shift_end <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_to_cnt    <= '0;
                    end
                end
                CS_SETUP: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (r_miso_sync && w_to_expire) r_timeout <= 1'b1;
                end
                SHIFT: begin
                    if (w_low_start) r_mosi <= r_tx[23];
                    if (w_sample) begin
                        r_tx  <= {r_tx[22:0], 1'b0};
                        r_rx  <= {r_rx[22:0], r_miso_sync};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_byte <= r_byte + 2'd1;
                    end
                    if (w_last_bit) r_shift_end <= 1'b1;
                end
                HOLD: begin
                    r_mosi     <= 1'b0;
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (w_next == DONE) begin
                        rsp_timeout <= r_timeout;
                        rsp_status  <= r_timeout ? 8'hFF : w_status;
                        rsp_rdata   <= (!r_timeout && r_rw && r_nbytes != 2'd1)
                                       ? r_rx[7:0] : 8'h00;
                    end
                end
                default: r_mosi <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cc1200_spi_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_cc1200_spi_master
// Brief   : Scoreboard bench with a behavioural CC1200 SPI slave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cc1200_spi_master;

    localparam int CLK_DIV     = 3;
    localparam int RDY_TIMEOUT = 64;
    localparam int CS_HOLD     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic       cmd_ext = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] rsp_status;
    logic       rsp_timeout;
    logic       busy;
    logic       SCLK_0;
    logic       MOSI_0;
    logic       MISO_0 = 1'b1;
    logic       CS_n_0;

    cc1200_spi_master #(
        .CLK_DIV     (CLK_DIV),
        .RDY_TIMEOUT (RDY_TIMEOUT),
        .CS_HOLD     (CS_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_ext     (cmd_ext),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .SCLK_0      (SCLK_0),
        .MOSI_0      (MOSI_0),
        .MISO_0      (MISO_0),
        .CS_n_0      (CS_n_0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] mosi;
        int          edges;
        logic [7:0]  st;
        logic [7:0]  rd;
        logic        to;
    } exp_t;

    typedef struct {
        logic [23:0] resp;
        bit          stall;
        int          delay;
    } plan_t;

    typedef struct {
        logic [23:0] mosi;
        int          edges;
        int          low;
    } obs_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    obs_t  obs_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- CC1200 slave model ----------------
    plan_t       cur;
    int          bit_idx = 0;
    int          sclk_edges = 0;
    int          cs_low_cycles = 0;
    logic [23:0] mosi_bits = '0;
    bit          ready = 0;
    int          last_rise = 0;

    always @(negedge CS_n_0) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else begin
            cur.resp = 24'hFFFFFF; cur.stall = 1; cur.delay = 0;
        end
        bit_idx = 0; sclk_edges = 0; cs_low_cycles = 0; mosi_bits = '0; ready = 0;
        chk("cs_high_gap", ((cyc - last_rise) >= CS_HOLD) ? 32'd1 : 32'd0, 32'd1);
    end

    always @(posedge clk) begin
        if (!CS_n_0) begin
            cs_low_cycles++;
            if (!cur.stall && !ready && cs_low_cycles >= cur.delay) begin
                ready = 1;
                MISO_0 = cur.resp[23];
            end
        end
    end

    always @(posedge SCLK_0) begin
        if (!CS_n_0) begin
            mosi_bits = {mosi_bits[22:0], MOSI_0};
            sclk_edges++;
        end
    end

    always @(negedge SCLK_0) begin
        if (!CS_n_0) begin
            bit_idx++;
            if (bit_idx < 24) MISO_0 = cur.resp[23 - bit_idx];
        end
    end

    always @(posedge CS_n_0) begin
        obs_t o;
        MISO_0 = 1'b1;
        last_rise = cyc;
        o.mosi = mosi_bits; o.edges = sclk_edges; o.low = cs_low_cycles;
        obs_q.push_back(o);
    end

    // ---------------- response monitor ----------------
    bit prev_valid = 0;
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            exp_t e;
            obs_t o;
            chk("rsp_valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_status", {24'd0, rsp_status}, {24'd0, e.st});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rd});
                chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
                if (obs_q.size() == 0) begin
                    chk("frame_seen", 32'd0, 32'd1);
                end else begin
                    o = obs_q.pop_front();
                    chk("mosi_bytes", {8'd0, o.mosi}, {8'd0, e.mosi});
                    chk("sclk_edges", o.edges, e.edges);
                    if (e.to) chk("cs_low_len", o.low, RDY_TIMEOUT);
                end
            end
        end
        prev_valid = rsp_valid;
    end

    // ---------------- reference model + stimulus ----------------
    function automatic int frame_len(input bit ext, input int addr);
        int a6;
        a6 = addr % 64;
        if (ext) return 3;
        if (a6 >= 'h30 && a6 <= 'h3D) return 1;
        return 2;
    endfunction

    task automatic issue(input bit rw, input bit ext, input int addr, input int wdata,
                         input int st, input int rd, input bit stall);
        exp_t  e;
        plan_t p;
        int    nb, hdr, data, n;
        nb   = frame_len(ext, addr);
        hdr  = (rw ? 128 : 0) + (ext ? 'h2F : addr % 64);
        data = rw ? 0 : wdata;
        if (stall) begin
            e.mosi = 0; e.edges = 0; e.st = 8'hFF; e.rd = 8'h00; e.to = 1;
        end else begin
            if (nb == 1)      e.mosi = 24'(hdr);
            else if (nb == 2) e.mosi = 24'(hdr * 256 + data);
            else              e.mosi = 24'(hdr * 65536 + addr * 256 + data);
            e.edges = 8 * nb;
            e.st = 8'(st);
            e.rd = (rw && nb > 1) ? 8'(rd) : 8'h00;
            e.to = 0;
        end
        if (nb == 1)      p.resp = 24'(st * 65536);
        else if (nb == 2) p.resp = 24'(st * 65536 + rd * 256);
        else              p.resp = 24'(st * 65536 + $urandom_range(0, 255) * 256 + rd);
        p.stall = stall;
        p.delay = $urandom_range(1, 6);
        plan_q.push_back(p);
        exp_q.push_back(e);
        @(negedge clk);
        cmd_rw = rw; cmd_ext = ext; cmd_addr = 8'(addr); cmd_wdata = 8'(wdata);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("accept_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("ready_drop", {31'd0, cmd_ready}, 32'd0);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("drain_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_regs", {15'd0, rsp_timeout, rsp_status, rsp_rdata}, 32'd0);
        chk("rst_pins", {29'd0, SCLK_0, MOSI_0, CS_n_0}, 32'd1);
        rst = 1'b0;
        obs_q.delete();
        repeat (2) @(negedge clk);

        issue(0, 0, 'h0A, 'h5C, 'h0F, 0, 0);
        issue(1, 0, 'h01, 0, 'h0F, 'hA5, 0);
        issue(1, 1, 'h8F, 0, 'h0F, 'h20, 0);
        issue(0, 0, 'h36, 0, 'h2A, 0, 0);
        issue(0, 0, 'h10, 'h33, 0, 0, 1);
        issue(1, 0, 'h02, 0, 'h0F, 'h5A, 0);
        drain();

        // Reset in the middle of byte 1 of a read frame.
        issue(1, 0, 'h05, 0, 'h0F, 'hC3, 0);
        n = 0;
        while (sclk_edges < 12 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("midframe_bound", 32'd0, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_pins", {30'd0, CS_n_0, SCLK_0}, 32'd2);
        chk("midrst_ready", {30'd0, cmd_ready, busy}, 32'd2);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);

        issue(0, 0, 'h0B, 'h11, 'h1F, 0, 0);
        issue(1, 0, 'h0C, 0, 'h1F, 'h77, 0);
        drain();

        for (int i = 0; i < 20; i++) begin
            int kind, addr;
            bit ext, stall;
            kind  = $urandom_range(0, 7);
            stall = (kind == 0);
            ext   = (kind == 3 || kind == 4);
            if (kind == 1 || kind == 2) addr = $urandom_range('h30, 'h3D) + 64 * $urandom_range(0, 3);
            else                        addr = $urandom_range(0, 255);
            issue($urandom_range(0, 1), ext, addr, $urandom_range(0, 255),
                  $urandom_range(0, 127), $urandom_range(0, 255), stall);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
